// File: rtl/dualmem_widen_param.sv
// True-dual-port RAM: narrow port A and wide port B share one array, with byte enables and a zeroing init sequencer.
// Optional macro DUALMEM_WIDEN_OUTREG_EN adds a second read output stage (read latency 2).
module dualmem_widen_param #(
   parameter int B_WIDTH = 64,
   parameter int RATIO   = 4,
   parameter int B_DEPTH = 512,
   localparam int A_WIDTH = B_WIDTH / RATIO,
   localparam int B_AW    = $clog2(B_DEPTH),
   localparam int A_AW    = B_AW + $clog2(RATIO)
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   init_busy,
   input  logic                   a_req,
   input  logic [A_WIDTH/8-1:0]   a_we,
   input  logic [A_AW-1:0]        a_addr,
   input  logic [A_WIDTH-1:0]     a_wdata,
   output logic [A_WIDTH-1:0]     a_rdata,
   output logic                   a_rvalid,
   input  logic                   b_req,
   input  logic [B_WIDTH/8-1:0]   b_we,
   input  logic [B_AW-1:0]        b_addr,
   input  logic [B_WIDTH-1:0]     b_wdata,
   output logic [B_WIDTH-1:0]     b_rdata,
   output logic                   b_rvalid,
   output logic                   collision
);

   localparam int A_BYTES = A_WIDTH / 8;
   localparam int B_BYTES = B_WIDTH / 8;
   localparam int LR      = $clog2(RATIO);

   if ((RATIO < 1) || ((RATIO & (RATIO - 1)) != 0) || ((B_WIDTH % (RATIO * 8)) != 0) ||
       (B_DEPTH < 2) || ((B_DEPTH & (B_DEPTH - 1)) != 0)) begin : gBadParams
      $error("dualmem_widen_param: illegal RATIO/B_WIDTH/B_DEPTH combination");
   end

   typedef enum logic {INIT, RUN} stateT;

   stateT             state_q, state_d;
   logic [B_AW-1:0]   cnt_q, cnt_d;

   logic [B_WIDTH-1:0] mem_q [B_DEPTH];

   logic [B_AW-1:0]    aWord;
   int                 aLane;
   logic [B_BYTES-1:0] aWideWe;
   logic [B_WIDTH-1:0] aWideData;
   logic               aWr, aRd, bWr, bRd, active;

   logic [A_WIDTH-1:0] aRdata_q;
   logic [B_WIDTH-1:0] bRdata_q;
   logic               aRvalid_q, bRvalid_q, collision_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == B_AW'(B_DEPTH - 1)) state_d = RUN;
         end
         RUN:     state_d = RUN;
         default: state_d = INIT;
      endcase
   end

   assign init_busy = (state_q == INIT);
   assign active    = (state_q == RUN) && !rst;

   // A narrow access becomes a wide access with its byte enables shifted into its lane.
   assign aWord     = B_AW'(a_addr >> LR);
   assign aLane     = int'(a_addr & A_AW'(RATIO - 1));
   assign aWideWe   = B_BYTES'(a_we) << (aLane * A_BYTES);
   assign aWideData = {RATIO{a_wdata}};

   assign aWr = active && a_req && (|a_we);
   assign aRd = active && a_req && !(|a_we);
   assign bWr = active && b_req && (|b_we);
   assign bRd = active && b_req && !(|b_we);

   // Port B is written after port A so it owns any byte both ports enable.
   always_ff @(posedge clk) begin
      if (state_q == INIT) begin
         mem_q[cnt_q] <= '0;
      end else begin
         for (int k = 0; k < B_BYTES; k++) begin
            if (aWr && aWideWe[k]) mem_q[aWord][k*8 +: 8] <= aWideData[k*8 +: 8];
            if (bWr && b_we[k])    mem_q[b_addr][k*8 +: 8] <= b_wdata[k*8 +: 8];
         end
      end
   end

   // Reads see the array before this cycle's writes land (read-first).
   always_ff @(posedge clk) begin
      if (rst) begin
         aRdata_q    <= '0;
         bRdata_q    <= '0;
         aRvalid_q   <= 1'b0;
         bRvalid_q   <= 1'b0;
         collision_q <= 1'b0;
      end else begin
         aRvalid_q   <= aRd;
         bRvalid_q   <= bRd;
         collision_q <= aWr && bWr && (aWord == b_addr) && (|(aWideWe & b_we));
         if (aRd) aRdata_q <= A_WIDTH'(mem_q[aWord] >> (aLane * A_WIDTH));
         if (bRd) bRdata_q <= mem_q[b_addr];
      end
   end

   assign collision = collision_q;

`ifdef DUALMEM_WIDEN_OUTREG_EN
   logic [A_WIDTH-1:0] aRdataOut_q;
   logic [B_WIDTH-1:0] bRdataOut_q;
   logic               aRvalidOut_q, bRvalidOut_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         aRdataOut_q  <= '0;
         bRdataOut_q  <= '0;
         aRvalidOut_q <= 1'b0;
         bRvalidOut_q <= 1'b0;
      end else begin
         aRvalidOut_q <= aRvalid_q;
         bRvalidOut_q <= bRvalid_q;
         if (aRvalid_q) aRdataOut_q <= aRdata_q;
         if (bRvalid_q) bRdataOut_q <= bRdata_q;
      end
   end

   assign a_rdata  = aRdataOut_q;
   assign b_rdata  = bRdataOut_q;
   assign a_rvalid = aRvalidOut_q;
   assign b_rvalid = bRvalidOut_q;
`else
   assign a_rdata  = aRdata_q;
   assign b_rdata  = bRdata_q;
   assign a_rvalid = aRvalid_q;
   assign b_rvalid = bRvalid_q;
`endif

endmodule

// File: tb/tb_dualmem_widen_param.sv
// Scoreboard bench for dualmem_widen_param: reads push expected data and due cycle, a negedge monitor checks them.
module tb_dualmem_widen_param;

   localparam int B_WIDTH = 64;
   localparam int RATIO   = 4;
   localparam int B_DEPTH = 512;
   localparam int A_WIDTH = 16;
   localparam int B_AW    = 9;
   localparam int A_AW    = 11;
`ifdef DUALMEM_WIDEN_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      logic [63:0] data;
      int          due;
   } expT;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 init_busy;
   logic                 a_req;
   logic [1:0]           a_we;
   logic [A_AW-1:0]      a_addr;
   logic [A_WIDTH-1:0]   a_wdata;
   logic [A_WIDTH-1:0]   a_rdata;
   logic                 a_rvalid;
   logic                 b_req;
   logic [7:0]           b_we;
   logic [B_AW-1:0]      b_addr;
   logic [B_WIDTH-1:0]   b_wdata;
   logic [B_WIDTH-1:0]   b_rdata;
   logic                 b_rvalid;
   logic                 collision;

   expT aQ[$];
   expT bQ[$];
   expT aExp, bExp;
   int  cycleCount = 0;
   int  checkCount = 0;
   int  passCount  = 0;
   int  busyCycles;

   dualmem_widen_param #(.B_WIDTH(B_WIDTH), .RATIO(RATIO), .B_DEPTH(B_DEPTH)) dut (
      .clk(clk), .rst(rst), .init_busy(init_busy),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rdata(a_rdata), .a_rvalid(a_rvalid),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_rdata(b_rdata), .b_rvalid(b_rvalid), .collision(collision)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCount++;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
   endtask

   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic aReq, input logic [1:0] aWe, input logic [A_AW-1:0] aAddr,
                                input logic [15:0] aWdata, input logic bReq, input logic [7:0] bWe,
                                input logic [B_AW-1:0] bAddr, input logic [63:0] bWdata);
      a_req = aReq; a_we = aWe; a_addr = aAddr; a_wdata = aWdata;
      b_req = bReq; b_we = bWe; b_addr = bAddr; b_wdata = bWdata;
      stepClk();
      a_req = 1'b0; a_we = '0;
      b_req = 1'b0; b_we = '0;
   endtask

   task automatic readA(input logic [A_AW-1:0] addr, input logic [15:0] expData);
      aQ.push_back('{data: 64'(expData), due: cycleCount + LAT});
      applyStimulus(1'b1, 2'b00, addr, 16'h0, 1'b0, 8'h00, '0, 64'h0);
   endtask

   task automatic readB(input logic [B_AW-1:0] addr, input logic [63:0] expData);
      bQ.push_back('{data: expData, due: cycleCount + LAT});
      applyStimulus(1'b0, 2'b00, '0, 16'h0, 1'b1, 8'h00, addr, 64'h0);
   endtask

   // Every rvalid must match the oldest outstanding read, both in data and in arrival cycle.
   always @(negedge clk) begin
      if (a_rvalid) begin
         if (aQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL aUnexpected: a_rvalid with rdata %h, expected no read pending", a_rdata);
         end else begin
            aExp = aQ.pop_front();
            checkOutput("aRdata", 64'(a_rdata), aExp.data);
            checkOutput("aLatency", 64'(cycleCount), 64'(aExp.due));
         end
      end
      if (b_rvalid) begin
         if (bQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL bUnexpected: b_rvalid with rdata %h, expected no read pending", b_rdata);
         end else begin
            bExp = bQ.pop_front();
            checkOutput("bRdata", b_rdata, bExp.data);
            checkOutput("bLatency", 64'(cycleCount), 64'(bExp.due));
         end
      end
   end

   initial begin
      rst = 1'b1;
      a_req = 1'b0; a_we = '0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_we = '0; b_addr = '0; b_wdata = '0;
      repeat (3) stepClk();
      checkOutput("rstInitBusy", 64'(init_busy), 64'd1);
      checkOutput("rstARvalid", 64'(a_rvalid), 64'd0);
      checkOutput("rstBRvalid", 64'(b_rvalid), 64'd0);
      checkOutput("rstARdata", 64'(a_rdata), 64'd0);
      checkOutput("rstBRdata", b_rdata, 64'd0);
      checkOutput("rstCollision", 64'(collision), 64'd0);

      $display("[TB] init sequence after reset");
      rst = 1'b0;
      busyCycles = 0;
      while (init_busy && busyCycles < 2000) begin
         busyCycles++;
         stepClk();
      end
      checkOutput("initBusyCycles", 64'(busyCycles), 64'd512);
      checkOutput("initBusyLow", 64'(init_busy), 64'd0);

      for (int i = 0; i < B_DEPTH; i++) readB(B_AW'(i), 64'h0);
      repeat (3) stepClk();

      $display("[TB] wide write, narrow reads");
      applyStimulus(1'b0, 2'b00, '0, 16'h0, 1'b1, 8'hFF, 9'd5, 64'h1122334455667788);
      readA(11'd20, 16'h7788);
      readA(11'd21, 16'h5566);
      readA(11'd22, 16'h3344);
      readA(11'd23, 16'h1122);

      $display("[TB] narrow writes with byte enables");
      applyStimulus(1'b1, 2'b11, 11'd21, 16'hBEEF, 1'b0, 8'h00, '0, 64'h0);
      readB(9'd5, 64'h11223344BEEF7788);
      applyStimulus(1'b1, 2'b01, 11'd22, 16'hCDAB, 1'b0, 8'h00, '0, 64'h0);
      readB(9'd5, 64'h112233ABBEEF7788);

      $display("[TB] overlapping write/write");
      applyStimulus(1'b1, 2'b11, 11'd20, 16'hAAAA, 1'b1, 8'h01, 9'd5, 64'h0);
      checkOutput("collisionOverlap", 64'(collision), 64'd1);
      stepClk();
      checkOutput("collisionPulseEnd", 64'(collision), 64'd0);
      readB(9'd5, 64'h112233ABBEEFAA00);

      $display("[TB] disjoint-byte write/write");
      applyStimulus(1'b1, 2'b10, 11'd20, 16'h5500, 1'b1, 8'h01, 9'd5, 64'h11);
      checkOutput("collisionDisjoint", 64'(collision), 64'd0);
      readB(9'd5, 64'h112233ABBEEF5511);

      $display("[TB] read-first across ports");
      aQ.push_back('{data: 64'h0, due: cycleCount + LAT});
      applyStimulus(1'b1, 2'b00, 11'd28, 16'h0, 1'b1, 8'hFF, 9'd7, 64'hFFFFFFFFFFFFFFFF);
      checkOutput("collisionReadWrite", 64'(collision), 64'd0);
      readA(11'd28, 16'hFFFF);
      repeat (3) stepClk();

      $display("[TB] reset during a pending read");
      if (LAT == 1) aQ.push_back('{data: 64'h5511, due: cycleCount + 1});
      applyStimulus(1'b1, 2'b00, 11'd20, 16'h0, 1'b0, 8'h00, '0, 64'h0);
      rst = 1'b1;
      stepClk();
      checkOutput("midRstARvalid", 64'(a_rvalid), 64'd0);
      checkOutput("midRstInitBusy", 64'(init_busy), 64'd1);
      checkOutput("midRstARdata", 64'(a_rdata), 64'd0);
      checkOutput("midRstBRdata", b_rdata, 64'd0);
      rst = 1'b0;
      busyCycles = 0;
      while (init_busy && busyCycles < 2000) begin
         busyCycles++;
         if (busyCycles == 500)
            applyStimulus(1'b1, 2'b00, 11'd0, 16'h0, 1'b1, 8'hFF, 9'd3, 64'hDEADBEEFCAFEF00D);
         else
            stepClk();
      end
      checkOutput("reinitBusyCycles", 64'(busyCycles), 64'd512);
      readB(9'd5, 64'h0);
      readB(9'd3, 64'h0);
      readA(11'd20, 16'h0);
      repeat (4) stepClk();

      checkOutput("aQueueDrained", 64'(aQ.size()), 64'd0);
      checkOutput("bQueueDrained", 64'(bQ.size()), 64'd0);
      checkOutput("collisionIdle", 64'(collision), 64'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
